// File: rtl/hdc_input_pkg.sv
// Shared types and CSR_INPUT field layout for the HDC input path.
// Used by the input sequencer and its token FIFO.
package hdc_input_pkg;

  localparam int TOK_VALUE_W = 6;
  localparam int TOK_SHIFT_W = 6;

  // CSR_INPUT bit positions
  localparam int CSR_INPUT_W         = 14;
  localparam int CSR_IN_VALID_BIT    = 0;
  localparam int CSR_IN_VALUE_LSB    = 1;
  localparam int CSR_IN_SHIFT_LSB    = 7;
  localparam int CSR_IN_DONE_BIT     = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [TOK_VALUE_W-1:0] value;
    logic [TOK_SHIFT_W-1:0] shift;
    logic                   last;
    logic                   bubble;
  } sample_tok_t;

  function automatic sample_tok_t make_tok(
    input logic [TOK_VALUE_W-1:0] value,
    input logic [TOK_SHIFT_W-1:0] shift,
    input logic                   last,
    input logic                   bubble
  );
    sample_tok_t t;
    t.value  = value;
    t.shift  = shift;
    t.last   = last;
    t.bubble = bubble;
    return t;
  endfunction

  // Builds a token straight from a raw CSR_INPUT word.
  function automatic sample_tok_t decode_csr_input(input logic [CSR_INPUT_W-1:0] w);
    return make_tok(w[CSR_IN_VALUE_LSB +: TOK_VALUE_W],
                    w[CSR_IN_SHIFT_LSB +: TOK_SHIFT_W],
                    w[CSR_IN_DONE_BIT],
                    !w[CSR_IN_VALID_BIT]);
  endfunction

endpackage

// File: rtl/hdc_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy count; head is read
// combinationally from storage, no empty-bypass.
module hdc_sync_fifo
  import hdc_input_pkg::*;
#(
  parameter  int  DEPTH = 4,
  parameter  type T     = sample_tok_t,
  localparam int  PTR_W = $clog2(DEPTH),
  localparam int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  always_comb begin
    push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
    pop_ok_s  = pop_i && (count_q != '0);
    count_d   = count_q;
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/csr_input_sequencer.sv
// Converts CSR_INPUT write strobes into sample tokens, buffers them and
// streams them to the encoder; reports in_ready/running back to CSR_STATUS.
module csr_input_sequencer
  import hdc_input_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int VALUE_W = TOK_VALUE_W,
  parameter  int SHIFT_W = TOK_SHIFT_W,
  localparam int LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               soft_clr_i,
  input  logic               wr_strobe_i,
  input  logic               in_valid_i,
  input  logic [VALUE_W-1:0] in_value_i,
  input  logic [SHIFT_W-1:0] shift_amount_i,
  input  logic               input_done_i,
  output logic               in_ready_o,
  output logic               running_o,
  output logic               s_valid_o,
  input  logic               s_ready_i,
  output logic [VALUE_W-1:0] s_value_o,
  output logic [SHIFT_W-1:0] s_shift_o,
  output logic               s_last_o,
  output logic               s_bubble_o,
  output logic               overflow_o,
  output logic [LVL_W-1:0]   level_o
);

  seq_state_e       state_q;
  logic             overflow_q;
  logic [LVL_W-1:0] level_s;
  sample_tok_t      push_tok_s;
  sample_tok_t      head_tok_s;
  logic             has_data_s;
  logic             in_ready_s;
  logic             push_s;
  logic             drop_s;
  logic             pop_s;

  always_comb begin
    has_data_s = in_valid_i || input_done_i;
    in_ready_s = (state_q == RUN) && (level_s < LVL_W'(DEPTH));
    push_s     = wr_strobe_i && in_ready_s && has_data_s && !soft_clr_i;
    drop_s     = wr_strobe_i && has_data_s && !in_ready_s;
    pop_s      = (level_s != '0) && s_ready_i;
    push_tok_s = make_tok(in_value_i, shift_amount_i, input_done_i, !in_valid_i);
  end

  hdc_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (sample_tok_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (soft_clr_i),
    .push_i  (push_s),
    .data_i  (push_tok_s),
    .pop_i   (pop_s),
    .data_o  (head_tok_s),
    .count_o (level_s)
  );

  // A dropped write outranks a same-cycle start so the loss is never hidden.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else if (soft_clr_i) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_q <= RUN;
        RUN:     if (push_s && input_done_i) state_q <= DRAIN;
        DRAIN:   if (pop_s && head_tok_s.last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (start_i && (state_q == IDLE)) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign in_ready_o = in_ready_s;
  assign running_o  = (state_q != IDLE);
  assign s_valid_o  = (level_s != '0);
  assign s_value_o  = head_tok_s.value;
  assign s_shift_o  = head_tok_s.shift;
  assign s_last_o   = head_tok_s.last;
  assign s_bubble_o = head_tok_s.bubble;
  assign overflow_o = overflow_q;
  assign level_o    = level_s;

endmodule

// File: tb/tb_csr_input_sequencer.sv
// Directed self-checking bench for csr_input_sequencer (DEPTH=4).
module tb_csr_input_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       soft_clr_i = 1'b0;
  logic       wr_strobe_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic [5:0] in_value_i = 6'd0;
  logic [5:0] shift_amount_i = 6'd0;
  logic       input_done_i = 1'b0;
  logic       in_ready_o;
  logic       running_o;
  logic       s_valid_o;
  logic       s_ready_i = 1'b0;
  logic [5:0] s_value_o;
  logic [5:0] s_shift_o;
  logic       s_last_o;
  logic       s_bubble_o;
  logic       overflow_o;
  logic [2:0] level_o;

  int checks = 0;
  int errors = 0;
  logic [13:0] tok_q [$];

  csr_input_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .soft_clr_i     (soft_clr_i),
    .wr_strobe_i    (wr_strobe_i),
    .in_valid_i     (in_valid_i),
    .in_value_i     (in_value_i),
    .shift_amount_i (shift_amount_i),
    .input_done_i   (input_done_i),
    .in_ready_o     (in_ready_o),
    .running_o      (running_o),
    .s_valid_o      (s_valid_o),
    .s_ready_i      (s_ready_i),
    .s_value_o      (s_value_o),
    .s_shift_o      (s_shift_o),
    .s_last_o       (s_last_o),
    .s_bubble_o     (s_bubble_o),
    .overflow_o     (overflow_o),
    .level_o        (level_o)
  );

  always #5 clk_i = ~clk_i;

  // Record each handshake half a cycle before the edge that completes it.
  always @(negedge clk_i) begin
    if (!rst_i && s_valid_o && s_ready_i) begin
      tok_q.push_back({s_last_o, s_bubble_o, s_shift_o, s_value_o});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic v, input logic [5:0] val, input logic [5:0] sh, input logic d);
    wr_strobe_i    = 1'b1;
    in_valid_i     = v;
    in_value_i     = val;
    shift_amount_i = sh;
    input_done_i   = d;
    step();
    wr_strobe_i    = 1'b0;
    in_valid_i     = 1'b0;
    input_done_i   = 1'b0;
    in_value_i     = 6'd0;
    shift_amount_i = 6'd0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_run"},  {31'd0, running_o},  32'd0);
    check_eq({tag, "_rdy"},  {31'd0, in_ready_o}, 32'd0);
    check_eq({tag, "_vld"},  {31'd0, s_valid_o},  32'd0);
    check_eq({tag, "_ovf"},  {31'd0, overflow_o}, 32'd0);
    check_eq({tag, "_lvl"},  {29'd0, level_o},    32'd0);
    check_eq({tag, "_tok"},  {18'd0, s_last_o, s_bubble_o, s_shift_o, s_value_o}, 32'd0);
  endtask

  task automatic check_tok(input string tag, input int idx, input logic [13:0] exp);
    logic [13:0] got;
    got = (idx < tok_q.size()) ? tok_q[idx] : 14'h3fff;
    check_eq(tag, {18'd0, got}, {18'd0, exp});
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    step();
    step();
    rst_i = 1'b0;
    step();
    check_all_zero("post_reset");

    // Basic flow with the encoder always ready
    s_ready_i = 1'b1;
    pulse_start();
    check_eq("basic_running", {31'd0, running_o}, 32'd1);
    check_eq("basic_in_ready", {31'd0, in_ready_o}, 32'd1);
    wr(1'b1, 6'd5, 6'd1, 1'b0);
    check_eq("basic_lat_valid", {31'd0, s_valid_o}, 32'd1);
    check_eq("basic_lat_value", {26'd0, s_value_o}, 32'd5);
    wr(1'b1, 6'd6, 6'd1, 1'b0);
    wr(1'b1, 6'd7, 6'd1, 1'b0);
    wr(1'b0, 6'd0, 6'd0, 1'b1);
    check_eq("basic_drain_run", {31'd0, running_o}, 32'd1);
    check_eq("basic_drain_rdy", {31'd0, in_ready_o}, 32'd0);
    check_eq("basic_bubble_last", {30'd0, s_last_o, s_bubble_o}, 32'd3);
    step();
    check_eq("basic_idle_after", {31'd0, running_o}, 32'd0);
    check_eq("basic_ntok", tok_q.size(), 32'd4);
    check_tok("basic_t0", 0, 14'h0045);
    check_tok("basic_t1", 1, 14'h0046);
    check_tok("basic_t2", 2, 14'h0047);
    check_tok("basic_t3", 3, 14'h3000);
    check_eq("basic_ovf", {31'd0, overflow_o}, 32'd0);

    // Backpressure, overflow and full-plus-pop
    tok_q.delete();
    s_ready_i = 1'b0;
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      wr(1'b1, 6'(i), 6'd2, 1'b0);
    end
    check_eq("bp_level4", {29'd0, level_o}, 32'd4);
    check_eq("bp_not_ready", {31'd0, in_ready_o}, 32'd0);
    check_eq("bp_ovf_before", {31'd0, overflow_o}, 32'd0);
    wr(1'b1, 6'd5, 6'd2, 1'b0);
    check_eq("bp_drop_level", {29'd0, level_o}, 32'd4);
    check_eq("bp_drop_ovf", {31'd0, overflow_o}, 32'd1);
    s_ready_i = 1'b1;
    wr(1'b1, 6'd9, 6'd2, 1'b0);
    check_eq("fullpop_level", {29'd0, level_o}, 32'd3);
    check_eq("fullpop_ovf", {31'd0, overflow_o}, 32'd1);
    step();
    step();
    step();
    check_eq("bp_empty", {29'd0, level_o}, 32'd0);
    check_eq("bp_ntok", tok_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_tok($sformatf("bp_t%0d", i), i, 14'h0080 + 14'(i + 1));
    end
    wr(1'b0, 6'd0, 6'd0, 1'b1);
    step();
    check_eq("bp_idle", {31'd0, running_o}, 32'd0);
    check_eq("bp_ovf_sticky", {31'd0, overflow_o}, 32'd1);
    pulse_start();
    check_eq("start_clears_ovf", {31'd0, overflow_o}, 32'd0);

    // Soft clear with a simultaneous write
    s_ready_i = 1'b0;
    wr(1'b1, 6'd11, 6'd0, 1'b0);
    wr(1'b1, 6'd12, 6'd0, 1'b0);
    check_eq("sclr_pre_level", {29'd0, level_o}, 32'd2);
    soft_clr_i = 1'b1;
    wr(1'b1, 6'd13, 6'd0, 1'b0);
    soft_clr_i = 1'b0;
    check_eq("sclr_level", {29'd0, level_o}, 32'd0);
    check_eq("sclr_running", {31'd0, running_o}, 32'd0);
    check_eq("sclr_valid", {31'd0, s_valid_o}, 32'd0);
    step();
    check_eq("sclr_no_push", {29'd0, level_o}, 32'd0);

    // Writes outside RUN
    wr(1'b0, 6'd1, 6'd1, 1'b0);
    check_eq("noop_no_ovf", {31'd0, overflow_o}, 32'd0);
    wr(1'b1, 6'd7, 6'd0, 1'b0);
    check_eq("idle_wr_ovf", {31'd0, overflow_o}, 32'd1);
    check_eq("idle_wr_level", {29'd0, level_o}, 32'd0);
    pulse_start();
    check_eq("idle_start_clr", {31'd0, overflow_o}, 32'd0);
    wr(1'b0, 6'd0, 6'd0, 1'b1);
    check_eq("drain_level", {29'd0, level_o}, 32'd1);
    wr(1'b1, 6'd3, 6'd0, 1'b0);
    check_eq("drain_wr_ovf", {31'd0, overflow_o}, 32'd1);
    check_eq("drain_wr_level", {29'd0, level_o}, 32'd1);
    check_eq("drain_running", {31'd0, running_o}, 32'd1);

    // Asynchronous reset between edges during DRAIN
    rst_i = 1'b1;
    #2;
    check_all_zero("async_rst");
    step();
    rst_i = 1'b0;
    step();
    tok_q.delete();
    s_ready_i = 1'b1;
    pulse_start();
    wr(1'b1, 6'd10, 6'd3, 1'b0);
    wr(1'b0, 6'd0, 6'd0, 1'b1);
    step();
    check_eq("resume_ntok", tok_q.size(), 32'd2);
    check_tok("resume_t0", 0, 14'h00ca);
    check_tok("resume_t1", 1, 14'h3000);
    check_eq("resume_idle", {31'd0, running_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
